toeplitz_fifo_sched: RTL and testbench

- Read-side scheduler for the 32-bit input FIFO (module_fifo) that feeds the Toeplitz hashing core.
- Per hash block, it drains SEED_WORDS seed words from the FIFO into the core's seed register file.
- It then streams DATA_WORDS message words to the core over a valid/ready handshake, waits for the core's completion, and reports block done.
- It owns module_fifo's rd_en; it is the only reader of the FIFO.

---
 rtl/toeplitz_fifo_sched_if.sv | 40 ++++
 rtl/toeplitz_fifo_sched.sv | 200 ++++++++++++++++++++
 tb/tb_toeplitz_fifo_sched.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/toeplitz_fifo_sched_if.sv
// rtl/toeplitz_fifo_sched_if.sv - handshake/bus bundle between the FIFO read scheduler, its FIFO and the hash core
//
// Purpose: groups the control, FIFO read, seed write and message stream signals
// of toeplitz_fifo_sched into one bundle.
// Modports:
//   master - scheduler view: drives rd_en, seed_*, dat_valid/dat_data/dat_last,
//            busy, block_done; samples start, abort, fifo_*, dat_ready, hash_done.
//   slave  - environment view (FIFO, hash core, controller): the mirror image.
interface toeplitz_fifo_sched_if #(
    parameter int DW = 32,
    parameter int AW = 4
) ();
    logic          start;
    logic          abort;
    logic          fifo_empty;
    logic [DW-1:0] fifo_out;
    logic          rd_en;
    logic          seed_we;
    logic [AW-1:0] seed_addr;
    logic [DW-1:0] seed_data;
    logic          dat_valid;
    logic [DW-1:0] dat_data;
    logic          dat_last;
    logic          dat_ready;
    logic          hash_done;
    logic          busy;
    logic          block_done;

    modport master (
        input  start, abort, fifo_empty, fifo_out, dat_ready, hash_done,
        output rd_en, seed_we, seed_addr, seed_data,
        output dat_valid, dat_data, dat_last, busy, block_done
    );

    modport slave (
        output start, abort, fifo_empty, fifo_out, dat_ready, hash_done,
        input  rd_en, seed_we, seed_addr, seed_data,
        input  dat_valid, dat_data, dat_last, busy, block_done
    );
endinterface

// File: rtl/toeplitz_fifo_sched.sv
// rtl/toeplitz_fifo_sched.sv - read-side scheduler feeding seed and message words from the input FIFO to the Toeplitz hash core
//
// Purpose: per block, drains SEED_WORDS seed words into the core's seed register
// file, then streams DATA_WORDS message words over a valid/ready handshake,
// waits for hash_done and pulses block_done. Sole reader of the FIFO.
// Ports:
//   clk_in - system clock, rising edge
//   rst    - asynchronous active-low reset
//   bus    - toeplitz_fifo_sched_if.master (start/abort, FIFO read, seed write,
//            message stream, hash_done, busy, block_done)
module toeplitz_fifo_sched #(
    parameter int DW         = 32,
    parameter int SEED_WORDS = 16,
    parameter int DATA_WORDS = 8,
    parameter int AW         = 4
) (
    input  logic                          clk_in,
    input  logic                          rst,
    toeplitz_fifo_sched_if.master         bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_STREAM,
        S_WAIT_HASH,
        S_DONE
    } state_t;

    localparam int MAXW = (SEED_WORDS > DATA_WORDS) ? SEED_WORDS : DATA_WORDS;
    localparam int CW   = $clog2(MAXW + 1);

    localparam logic [CW-1:0] SEED_LEN  = CW'(SEED_WORDS);
    localparam logic [CW-1:0] DATA_LEN  = CW'(DATA_WORDS);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WORDS - 1);
    localparam logic [AW-1:0] SEED_LAST = AW'(SEED_WORDS - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] req_cnt_q, req_cnt_d;
    logic [CW-1:0] xfer_cnt_q, xfer_cnt_d;
    logic          rd_q, rd_d;
    logic          seed_we_q, seed_we_d;
    logic [AW-1:0] seed_addr_q, seed_addr_d;
    logic [DW-1:0] seed_data_q, seed_data_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          head_v_q, head_v_d;
    logic [DW-1:0] head_q, head_d;
    logic          skid_v_q, skid_v_d;
    logic [DW-1:0] skid_q, skid_d;

    logic          rd_en_c;
    logic          pop;
    logic [1:0]    occ;

    // Read strobe. In STREAM, occ counts the words that will occupy the
    // two-entry buffer once this cycle's pop and the in-flight read (rd_q)
    // are accounted for; a new read is only issued if a slot is guaranteed.
    always_comb begin
        pop     = head_v_q & bus.dat_ready;
        occ     = 2'(head_v_q) + 2'(skid_v_q) + 2'(rd_q) - 2'(pop);
        rd_en_c = 1'b0;
        if (!bus.abort && !bus.fifo_empty) begin
            if (state_q == S_SEED) begin
                rd_en_c = (req_cnt_q < SEED_LEN);
            end else if (state_q == S_STREAM) begin
                rd_en_c = (req_cnt_q < DATA_LEN) && (occ < 2'd2);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        req_cnt_d   = req_cnt_q + CW'(rd_en_c);
        xfer_cnt_d  = xfer_cnt_q;
        rd_d        = rd_en_c;
        seed_we_d   = 1'b0;
        seed_addr_d = seed_addr_q;
        seed_data_d = seed_data_q;
        wr_ptr_d    = wr_ptr_q;
        head_v_d    = head_v_q;
        head_d      = head_q;
        skid_v_d    = skid_v_q;
        skid_d      = skid_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_SEED;
                    req_cnt_d  = '0;
                    wr_ptr_d   = '0;
                    xfer_cnt_d = '0;
                end
            end
            S_SEED: begin
                // FIFO data is valid the cycle after rd_en, so rd_q marks it.
                if (rd_q) begin
                    seed_we_d   = 1'b1;
                    seed_addr_d = wr_ptr_q;
                    seed_data_d = bus.fifo_out;
                    wr_ptr_d    = wr_ptr_q + AW'(1);
                end
                if (seed_we_q && (seed_addr_q == SEED_LAST)) begin
                    state_d   = S_STREAM;
                    req_cnt_d = '0;
                end
            end
            S_STREAM: begin
                // Pop first so an arriving word lands behind any remaining one.
                if (pop) begin
                    if (skid_v_q) begin
                        head_d   = skid_q;
                        skid_v_d = 1'b0;
                    end else begin
                        head_v_d = 1'b0;
                    end
                    xfer_cnt_d = xfer_cnt_q + CW'(1);
                    if (xfer_cnt_q == DATA_LAST) begin
                        state_d    = S_WAIT_HASH;
                        xfer_cnt_d = '0;
                    end
                end
                if (rd_q) begin
                    if (!head_v_d) begin
                        head_v_d = 1'b1;
                        head_d   = bus.fifo_out;
                    end else begin
                        skid_v_d = 1'b1;
                        skid_d   = bus.fifo_out;
                    end
                end
            end
            S_WAIT_HASH: begin
                if (bus.hash_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort drops everything, including a word already in flight.
        if (bus.abort) begin
            state_d     = S_IDLE;
            req_cnt_d   = '0;
            xfer_cnt_d  = '0;
            rd_d        = 1'b0;
            seed_we_d   = 1'b0;
            seed_addr_d = '0;
            seed_data_d = '0;
            wr_ptr_d    = '0;
            head_v_d    = 1'b0;
            head_d      = '0;
            skid_v_d    = 1'b0;
            skid_d      = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            req_cnt_q   <= '0;
            xfer_cnt_q  <= '0;
            rd_q        <= 1'b0;
            seed_we_q   <= 1'b0;
            seed_addr_q <= '0;
            seed_data_q <= '0;
            wr_ptr_q    <= '0;
            head_v_q    <= 1'b0;
            head_q      <= '0;
            skid_v_q    <= 1'b0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            req_cnt_q   <= req_cnt_d;
            xfer_cnt_q  <= xfer_cnt_d;
            rd_q        <= rd_d;
            seed_we_q   <= seed_we_d;
            seed_addr_q <= seed_addr_d;
            seed_data_q <= seed_data_d;
            wr_ptr_q    <= wr_ptr_d;
            head_v_q    <= head_v_d;
            head_q      <= head_d;
            skid_v_q    <= skid_v_d;
            skid_q      <= skid_d;
        end
    end

    assign bus.rd_en      = rd_en_c;
    assign bus.seed_we    = seed_we_q;
    assign bus.seed_addr  = seed_addr_q;
    assign bus.seed_data  = seed_data_q;
    assign bus.dat_valid  = head_v_q;
    assign bus.dat_data   = head_q;
    assign bus.dat_last   = head_v_q && (xfer_cnt_q == DATA_LAST);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.block_done = (state_q == S_DONE);
endmodule

// File: tb/tb_toeplitz_fifo_sched.sv
// tb/tb_toeplitz_fifo_sched.sv - directed self-checking bench for toeplitz_fifo_sched
module tb_toeplitz_fifo_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    toeplitz_fifo_sched_if #(.DW(32), .AW(4)) bus ();

    toeplitz_fifo_sched #(.DW(32), .SEED_WORDS(16), .DATA_WORDS(8), .AW(4)) dut (
        .clk_in (clk),
        .rst    (rst_n),
        .bus    (bus)
    );

    // FIFO model: word i holds value i; fifo_out is valid the cycle after rd_en.
    logic [31:0] mem [0:63];
    int          fill = 0;
    int          rd_ptr = 0;
    logic        force_empty = 1'b0;
    logic        fifo_clr = 1'b0;

    assign bus.fifo_empty = force_empty || (rd_ptr >= fill);

    always @(posedge clk) begin
        if (fifo_clr) begin
            rd_ptr <= 0;
        end else if (bus.rd_en) begin
            bus.fifo_out <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic fifo_reset;
        @(posedge clk); #1;
        fifo_clr = 1'b1;
        @(posedge clk); #1;
        fifo_clr = 1'b0;
        fill = 24;
    endtask

    task automatic idle_inputs;
        bus.start = 1'b0; bus.abort = 1'b0; bus.hash_done = 1'b0;
        bus.dat_ready = 1'b1; force_empty = 1'b0;
    endtask

    task automatic test_reset;
        logic [73:0] obs;
        #2 rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            bus.start = 1'($urandom); bus.abort = 1'($urandom);
            bus.hash_done = 1'($urandom); bus.dat_ready = 1'($urandom);
            force_empty = 1'($urandom);
            @(negedge clk);
            obs = {bus.rd_en, bus.seed_we, bus.seed_addr, bus.seed_data, bus.dat_valid,
                   bus.dat_data, bus.dat_last, bus.busy, bus.block_done};
            n_cmp++;
            if (obs !== 74'd0) begin
                n_bad++; $display("FAIL reset_outputs k=%0d got %h want 0", k, obs);
            end
        end
        @(posedge clk); #1;
        idle_inputs();
        fill = 24;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.rd_en, bus.busy} !== 2'b00) begin
                n_bad++; $display("FAIL post_reset_idle k=%0d got rd_en=%b busy=%b want 0 0", k, bus.rd_en, bus.busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_full_block;
        logic e_rd, e_we, e_dv;
        fifo_reset(); idle_inputs();
        for (int k = 0; k <= 40; k++) begin
            @(posedge clk); #1;
            bus.start = (k == 0); bus.hash_done = (k == 32);
            @(negedge clk);
            e_rd = (k >= 1 && k <= 16) || (k >= 19 && k <= 26);
            e_we = (k >= 3 && k <= 18);
            e_dv = (k >= 21 && k <= 28);
            n_cmp++;
            if (bus.rd_en !== e_rd) begin n_bad++; $display("FAIL full_rd_en k=%0d got %b want %b", k, bus.rd_en, e_rd); end
            n_cmp++;
            if (bus.seed_we !== e_we) begin n_bad++; $display("FAIL full_seed_we k=%0d got %b want %b", k, bus.seed_we, e_we); end
            if (e_we) begin
                n_cmp++;
                if (bus.seed_addr !== 4'(k - 3) || bus.seed_data !== 32'(k - 3)) begin
                    n_bad++; $display("FAIL full_seed_word k=%0d got a=%0d d=%h want a=%0d d=%h", k, bus.seed_addr, bus.seed_data, k - 3, k - 3);
                end
            end
            n_cmp++;
            if (bus.dat_valid !== e_dv) begin n_bad++; $display("FAIL full_dat_valid k=%0d got %b want %b", k, bus.dat_valid, e_dv); end
            if (e_dv) begin
                n_cmp++;
                if (bus.dat_data !== 32'(k - 5)) begin n_bad++; $display("FAIL full_dat_data k=%0d got %h want %h", k, bus.dat_data, 32'(k - 5)); end
            end
            n_cmp++;
            if (bus.dat_last !== (k == 28)) begin n_bad++; $display("FAIL full_dat_last k=%0d got %b want %b", k, bus.dat_last, k == 28); end
            n_cmp++;
            if (bus.block_done !== (k == 33)) begin n_bad++; $display("FAIL full_block_done k=%0d got %b want %b", k, bus.block_done, k == 33); end
            n_cmp++;
            if (bus.busy !== (k >= 1 && k <= 33)) begin n_bad++; $display("FAIL full_busy k=%0d got %b want %b", k, bus.busy, k >= 1 && k <= 33); end
        end
    endtask

    task automatic test_backpressure;
        logic        e_rd, e_dv;
        logic [31:0] e_d;
        int          nxf;
        nxf = 0;
        fifo_reset(); idle_inputs();
        for (int k = 0; k <= 42; k++) begin
            @(posedge clk); #1;
            bus.start = (k == 0); bus.hash_done = (k == 36);
            bus.dat_ready = !(k >= 23 && k <= 27);
            @(negedge clk);
            e_rd = (k >= 1 && k <= 16) || (k >= 19 && k <= 22) || (k >= 28 && k <= 31);
            e_dv = (k >= 21 && k <= 33);
            e_d  = (k <= 22) ? 32'(k - 5) : (k <= 28) ? 32'h12 : 32'(k - 10);
            n_cmp++;
            if (bus.rd_en !== e_rd) begin n_bad++; $display("FAIL bp_rd_en k=%0d got %b want %b", k, bus.rd_en, e_rd); end
            n_cmp++;
            if (bus.dat_valid !== e_dv) begin n_bad++; $display("FAIL bp_dat_valid k=%0d got %b want %b", k, bus.dat_valid, e_dv); end
            if (e_dv) begin
                n_cmp++;
                if (bus.dat_data !== e_d) begin n_bad++; $display("FAIL bp_dat_data k=%0d got %h want %h", k, bus.dat_data, e_d); end
            end
            n_cmp++;
            if (bus.dat_last !== (k == 33)) begin n_bad++; $display("FAIL bp_dat_last k=%0d got %b want %b", k, bus.dat_last, k == 33); end
            if (bus.dat_valid && bus.dat_ready) begin
                n_cmp++;
                if (bus.dat_data !== 32'(16 + nxf)) begin n_bad++; $display("FAIL bp_order xfer=%0d got %h want %h", nxf, bus.dat_data, 32'(16 + nxf)); end
                nxf++;
            end
            n_cmp++;
            if (bus.block_done !== (k == 37)) begin n_bad++; $display("FAIL bp_block_done k=%0d got %b want %b", k, bus.block_done, k == 37); end
        end
        n_cmp++;
        if (nxf != 8) begin n_bad++; $display("FAIL bp_xfer_count got %0d want 8", nxf); end
    endtask

    task automatic test_underrun;
        logic e_rd, e_we, e_dv;
        fifo_reset(); idle_inputs();
        for (int k = 0; k <= 40; k++) begin
            @(posedge clk); #1;
            bus.start = (k == 0); bus.hash_done = (k == 35);
            force_empty = (k >= 10 && k <= 13);
            @(negedge clk);
            e_rd = (k >= 1 && k <= 9) || (k >= 14 && k <= 20) || (k >= 23 && k <= 30);
            e_we = (k >= 3 && k <= 11) || (k >= 16 && k <= 22);
            e_dv = (k >= 25 && k <= 32);
            n_cmp++;
            if (bus.rd_en !== e_rd) begin n_bad++; $display("FAIL ur_rd_en k=%0d got %b want %b", k, bus.rd_en, e_rd); end
            n_cmp++;
            if (bus.seed_we !== e_we) begin n_bad++; $display("FAIL ur_seed_we k=%0d got %b want %b", k, bus.seed_we, e_we); end
            if (e_we) begin
                n_cmp++;
                if (bus.seed_addr !== 4'((k <= 11) ? k - 3 : k - 7) || bus.seed_data !== 32'((k <= 11) ? k - 3 : k - 7)) begin
                    n_bad++; $display("FAIL ur_seed_word k=%0d got a=%0d d=%h want %0d", k, bus.seed_addr, bus.seed_data, (k <= 11) ? k - 3 : k - 7);
                end
            end
            n_cmp++;
            if (bus.dat_valid !== e_dv) begin n_bad++; $display("FAIL ur_dat_valid k=%0d got %b want %b", k, bus.dat_valid, e_dv); end
            if (e_dv) begin
                n_cmp++;
                if (bus.dat_data !== 32'(k - 9)) begin n_bad++; $display("FAIL ur_dat_data k=%0d got %h want %h", k, bus.dat_data, 32'(k - 9)); end
            end
            n_cmp++;
            if (bus.block_done !== (k == 36)) begin n_bad++; $display("FAIL ur_block_done k=%0d got %b want %b", k, bus.block_done, k == 36); end
        end
    endtask

    task automatic test_start_ignored;
        int n_done;
        n_done = 0;
        fifo_reset(); idle_inputs();
        for (int k = 0; k <= 45; k++) begin
            @(posedge clk); #1;
            bus.start = (k == 0) || (k == 24); bus.hash_done = (k == 32);
            @(negedge clk);
            if (bus.block_done) n_done++;
            n_cmp++;
            if (bus.busy !== (k >= 1 && k <= 33)) begin n_bad++; $display("FAIL ign_busy k=%0d got %b want %b", k, bus.busy, k >= 1 && k <= 33); end
        end
        n_cmp++;
        if (n_done != 1) begin n_bad++; $display("FAIL ign_done_count got %0d want 1", n_done); end
    endtask

    task automatic test_abort;
        fifo_reset(); idle_inputs();
        for (int k = 0; k <= 26; k++) begin
            @(posedge clk); #1;
            bus.start = (k == 0); bus.abort = (k == 22);
            @(negedge clk);
            if (k == 22) begin
                n_cmp++;
                if (bus.rd_en !== 1'b0) begin n_bad++; $display("FAIL abort_rd_en got %b want 0", bus.rd_en); end
            end
            if (k >= 23) begin
                n_cmp++;
                if ({bus.rd_en, bus.seed_we, bus.dat_valid, bus.dat_last, bus.block_done, bus.busy, bus.dat_data} !== 38'd0) begin
                    n_bad++; $display("FAIL abort_cleared k=%0d got rd=%b we=%b dv=%b dl=%b bd=%b busy=%b dd=%h want all 0",
                                      k, bus.rd_en, bus.seed_we, bus.dat_valid, bus.dat_last, bus.block_done, bus.busy, bus.dat_data);
                end
            end
        end
        // abort beats start in IDLE and hash_done in WAIT_HASH
        fifo_reset(); idle_inputs();
        for (int k = 0; k <= 35; k++) begin
            @(posedge clk); #1;
            bus.start = (k == 0); bus.abort = (k == 0) || (k == 32);
            bus.hash_done = (k == 32);
            @(negedge clk);
            if (k == 1) begin
                n_cmp++;
                if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_over_start got busy=%b want 0", bus.busy); end
            end
            if (k == 2) begin
                bus.abort = 1'b0;
                bus.start = 1'b1;
            end
            if (k == 33) begin
                n_cmp++;
                if ({bus.block_done, bus.busy} !== 2'b00) begin
                    n_bad++; $display("FAIL abort_over_hash_done got bd=%b busy=%b want 0 0", bus.block_done, bus.busy);
                end
            end
        end
    endtask

    task automatic test_reset_mid_stream;
        logic [73:0] obs;
        fifo_reset(); idle_inputs();
        for (int k = 0; k <= 27; k++) begin
            @(posedge clk); #1;
            bus.start = (k == 0);
            if (k == 23) rst_n = 1'b0;
            if (k == 26) rst_n = 1'b1;
            @(negedge clk);
            if (k >= 23 && k <= 25) begin
                obs = {bus.rd_en, bus.seed_we, bus.seed_addr, bus.seed_data, bus.dat_valid,
                       bus.dat_data, bus.dat_last, bus.busy, bus.block_done};
                n_cmp++;
                if (obs !== 74'd0) begin n_bad++; $display("FAIL midrst_outputs k=%0d got %h want 0", k, obs); end
            end
            if (k >= 26) begin
                n_cmp++;
                if ({bus.rd_en, bus.busy} !== 2'b00) begin n_bad++; $display("FAIL midrst_idle k=%0d got rd=%b busy=%b want 0 0", k, bus.rd_en, bus.busy); end
            end
        end
        test_full_block();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'(i);
        idle_inputs();
        test_reset();
        test_full_block();
        test_backpressure();
        test_underrun();
        test_start_ignored();
        test_abort();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
